// File: rtl/uci_bestmove_emitter.sv
// uci_bestmove_emitter
//   Serialises a best move from the engine coordinator as the ASCII UCI reply
//   "bestmove <uci-move>" plus a line terminator. The reply goes out one byte
//   at a time over a valid/ready handshake toward the UART transmitter.
//
// Parameters
//   STALL_LIMIT : cycles char_out_valid may wait on char_out_ready before the
//                 reply is aborted (0 = wait forever)
//   PENDING_EN  : 1 = hold one move that arrives while busy, 0 = drop it
//
// Build option
//   UCI_CRLF_EN : when defined the terminator is CR LF, otherwise LF only
//
// Ports
//   clk_in, rst_in           clock, synchronous active-high reset
//   move_from_in/move_to_in  squares, [2:0] file a..h, [5:3] rank 1..8
//   move_promo_in            0 none, 1 n, 2 b, 3 r, 4 q, 5-7 none
//   move_valid_in            one-cycle strobe for the move fields
//   char_out/char_out_valid  byte source, held stable until accepted
//   char_out_ready           sink accept; transfer on valid && ready
//   busy_out                 reply in progress
//   drop_out                 one-cycle pulse, a move was discarded
//   stall_err_out            one-cycle pulse, reply aborted on stall
module uci_bestmove_emitter #(
  parameter int STALL_LIMIT = 0,
  parameter int PENDING_EN  = 1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [5:0] move_from_in,
  input  logic [5:0] move_to_in,
  input  logic [2:0] move_promo_in,
  input  logic       move_valid_in,
  output logic [7:0] char_out,
  output logic       char_out_valid,
  input  logic       char_out_ready,
  output logic       busy_out,
  output logic       drop_out,
  output logic       stall_err_out
);

  localparam int SW = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;

`ifdef UCI_CRLF_EN
  localparam logic [3:0] EOL_LAST = 4'd1;
`else
  localparam logic [3:0] EOL_LAST = 4'd0;
`endif

  typedef enum logic [1:0] {IDLE, PREFIX, MOVE, EOL} state_t;

  // Promotion only counts for a real move with a code of 1..4.
  function automatic logic [2:0] norm_promo(input logic [5:0] from,
                                            input logic [5:0] to,
                                            input logic [2:0] promo);
    if (from == to || promo == 3'd0 || promo > 3'd4) return 3'd0;
    return promo;
  endfunction

  state_t     state, state_nxt;
  logic [3:0] idx, idx_nxt;
  logic [5:0] from_q, to_q;
  logic [2:0] promo_q;
  logic       pend_q;
  logic [5:0] pfrom_q, pto_q;
  logic [2:0] ppromo_q;
  logic       valid_q, valid_nxt;
  logic [SW-1:0] stall_q;
  logic       drop_q, stall_err_q;

  logic       xfer, stall_abort, eol_done;
  logic       load_in, load_pend, store_pend, drop;
  logic [3:0] move_last;
  logic [5:0] sq;
  logic [7:0] char_cur;

  assign xfer        = valid_q && char_out_ready;
  assign stall_abort = (STALL_LIMIT > 0) && valid_q && !char_out_ready &&
                       (stall_q == SW'(STALL_LIMIT));
  assign eol_done    = xfer && (state == EOL) && (idx == EOL_LAST);
  assign move_last   = (promo_q != 3'd0) ? 4'd4 : 4'd3;

  // A strobe is taken straight into the working fields only when idle with
  // nothing pending; otherwise it competes for the single pending slot. The
  // slot is free this cycle if its current occupant is being started.
  assign load_in    = (state == IDLE) && !pend_q && move_valid_in;
  assign load_pend  = pend_q && ((state == IDLE) || eol_done);
  assign store_pend = move_valid_in && !load_in && (PENDING_EN != 0);
  assign drop       = move_valid_in && !load_in &&
                      ((PENDING_EN == 0) || (pend_q && !load_pend));

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin : next_state_logic
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (pend_q || move_valid_in) begin
          state_nxt = PREFIX;
          idx_nxt   = '0;
        end
      end
      default: begin
        if (stall_abort) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else if (xfer) begin
          case (state)
            PREFIX: begin
              if (idx == 4'd8) begin
                state_nxt = MOVE;
                idx_nxt   = '0;
              end else begin
                idx_nxt = idx + 4'd1;
              end
            end
            MOVE: begin
              if (idx == move_last) begin
                state_nxt = EOL;
                idx_nxt   = '0;
              end else begin
                idx_nxt = idx + 4'd1;
              end
            end
            default: begin
              if (idx == EOL_LAST) begin
                state_nxt = pend_q ? PREFIX : IDLE;
                idx_nxt   = '0;
              end else begin
                idx_nxt = idx + 4'd1;
              end
            end
          endcase
        end
      end
    endcase
    // Valid comes up one cycle after leaving IDLE and stays up when a pending
    // reply follows directly, so back-to-back replies need no bubble.
    valid_nxt = (state != IDLE) && (state_nxt != IDLE);
  end

  always_comb begin : char_select
    char_cur = 8'h00;
    sq       = (idx < 4'd2) ? from_q : to_q;
    case (state)
      PREFIX: begin
        case (idx)
          4'd0:    char_cur = 8'h62;
          4'd1:    char_cur = 8'h65;
          4'd2:    char_cur = 8'h73;
          4'd3:    char_cur = 8'h74;
          4'd4:    char_cur = 8'h6D;
          4'd5:    char_cur = 8'h6F;
          4'd6:    char_cur = 8'h76;
          4'd7:    char_cur = 8'h65;
          default: char_cur = 8'h20;
        endcase
      end
      MOVE: begin
        if (idx == 4'd4) begin
          case (promo_q)
            3'd1:    char_cur = 8'h6E;
            3'd2:    char_cur = 8'h62;
            3'd3:    char_cur = 8'h72;
            default: char_cur = 8'h71;
          endcase
        end else if (from_q == to_q) begin
          char_cur = 8'h30;
        end else if (!idx[0]) begin
          char_cur = 8'h61 + {5'b0, sq[2:0]};
        end else begin
          char_cur = 8'h31 + {5'b0, sq[5:3]};
        end
      end
      EOL: begin
`ifdef UCI_CRLF_EN
        char_cur = (idx == 4'd0) ? 8'h0D : 8'h0A;
`else
        char_cur = 8'h0A;
`endif
      end
      default: char_cur = 8'h00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= IDLE;
      idx         <= '0;
      valid_q     <= 1'b0;
      stall_q     <= '0;
      drop_q      <= 1'b0;
      stall_err_q <= 1'b0;
      pend_q      <= 1'b0;
      from_q      <= '0;
      to_q        <= '0;
      promo_q     <= '0;
      pfrom_q     <= '0;
      pto_q       <= '0;
      ppromo_q    <= '0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      valid_q     <= valid_nxt;
      drop_q      <= drop;
      stall_err_q <= stall_abort;

      if (!valid_q || xfer || stall_abort) stall_q <= '0;
      else if (STALL_LIMIT > 0)            stall_q <= stall_q + SW'(1);

      if (load_pend) begin
        from_q  <= pfrom_q;
        to_q    <= pto_q;
        promo_q <= norm_promo(pfrom_q, pto_q, ppromo_q);
      end else if (load_in) begin
        from_q  <= move_from_in;
        to_q    <= move_to_in;
        promo_q <= norm_promo(move_from_in, move_to_in, move_promo_in);
      end

      if (store_pend) begin
        pend_q   <= 1'b1;
        pfrom_q  <= move_from_in;
        pto_q    <= move_to_in;
        ppromo_q <= move_promo_in;
      end else if (load_pend) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign char_out       = valid_q ? char_cur : 8'h00;
  assign char_out_valid = valid_q;
  assign busy_out       = (state != IDLE);
  assign drop_out       = drop_q;
  assign stall_err_out  = stall_err_q;

endmodule

// File: tb/tb_uci_bestmove_emitter.sv
// Bench for uci_bestmove_emitter. Two instances share all inputs:
//   dut1: STALL_LIMIT=16, PENDING_EN=1
//   dut2: STALL_LIMIT=0,  PENDING_EN=0
// Expected replies are built as strings from the move encoding rules.
module tb_uci_bestmove_emitter;

`ifdef UCI_CRLF_EN
  localparam int EOL_LEN = 2;
`else
  localparam int EOL_LEN = 1;
`endif

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [5:0] move_from_in, move_to_in;
  logic [2:0] move_promo_in;
  logic       move_valid_in;
  logic       char_out_ready;
  logic [7:0] c1, c2;
  logic       v1, v2, busy1, busy2, drop1, drop2, se1, se2;

  int    n_checks = 0;
  int    n_fail   = 0;
  string s1 = "", s2 = "";
  int    nd1 = 0, nd2 = 0;
  bit    hold1 = 0, hold2 = 0;
  logic [7:0] c1_prev, c2_prev;
  bit    ready_rand = 0;
  int    low_run = 0;

  uci_bestmove_emitter #(.STALL_LIMIT(16), .PENDING_EN(1)) dut1 (
    .clk_in(clk_in), .rst_in(rst_in),
    .move_from_in(move_from_in), .move_to_in(move_to_in),
    .move_promo_in(move_promo_in), .move_valid_in(move_valid_in),
    .char_out(c1), .char_out_valid(v1), .char_out_ready(char_out_ready),
    .busy_out(busy1), .drop_out(drop1), .stall_err_out(se1)
  );

  uci_bestmove_emitter #(.STALL_LIMIT(0), .PENDING_EN(0)) dut2 (
    .clk_in(clk_in), .rst_in(rst_in),
    .move_from_in(move_from_in), .move_to_in(move_to_in),
    .move_promo_in(move_promo_in), .move_valid_in(move_valid_in),
    .char_out(c2), .char_out_valid(v2), .char_out_ready(char_out_ready),
    .busy_out(busy2), .drop_out(drop2), .stall_err_out(se2)
  );

  always #5 clk_in = ~clk_in;

  function automatic string esc(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h0A)      r = {r, "\\n"};
      else if (s[i] == 8'h0D) r = {r, "\\r"};
      else                    r = {r, $sformatf("%c", s[i])};
    end
    return r;
  endfunction

  function automatic string expect_reply(input int f, input int t, input int p);
    string pc = "-nbrq";
    string mv;
    if (f == t) mv = "0000";
    else begin
      mv = $sformatf("%c%c%c%c", 97 + f % 8, 49 + f / 8, 97 + t % 8, 49 + t / 8);
      if (p >= 1 && p <= 4) mv = {mv, $sformatf("%c", pc[p])};
    end
`ifdef UCI_CRLF_EN
    return {"bestmove ", mv, "\r\n"};
`else
    return {"bestmove ", mv, "\n"};
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_str(input string tag, input string obs, input string exp);
    n_checks++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, esc(obs), esc(exp));
    end
  endtask

  // Collect transferred bytes, count drop pulses, and check that a byte
  // left waiting is still presented unchanged (a stall abort excepted).
  always @(negedge clk_in) begin
    if (rst_in) begin
      hold1 = 0;
      hold2 = 0;
    end else begin
      if (hold1 && !se1) chk("hold1", {23'd0, v1, c1}, {23'd0, 1'b1, c1_prev});
      if (hold2 && !se2) chk("hold2", {23'd0, v2, c2}, {23'd0, 1'b1, c2_prev});
      if (v1 && char_out_ready) s1 = {s1, $sformatf("%c", c1)};
      if (v2 && char_out_ready) s2 = {s2, $sformatf("%c", c2)};
      if (drop1) nd1++;
      if (drop2) nd2++;
      hold1 = v1 && !char_out_ready;
      hold2 = v2 && !char_out_ready;
      c1_prev = c1;
      c2_prev = c2;
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
    if (ready_rand) begin
      // Roughly 40% ready, with low runs capped well under the stall limit.
      if (low_run >= 6) char_out_ready = 1'b1;
      else              char_out_ready = ($urandom_range(0, 99) < 40);
      low_run = char_out_ready ? 0 : low_run + 1;
    end
  endtask

  task automatic start_move(input int f, input int t, input int p);
    move_from_in  = 6'(f);
    move_to_in    = 6'(t);
    move_promo_in = 3'(p);
    move_valid_in = 1'b1;
    step();
    move_valid_in = 1'b0;
  endtask

  // Waits until both instances have been quiet for four cycles in a row.
  task automatic wait_idle(input int max, input string tag);
    int n = 0;
    int q = 0;
    while (q < 4 && n < max) begin
      step();
      n++;
      if (busy1 || busy2 || v1 || v2) q = 0;
      else                            q++;
    end
    chk(tag, 32'(q >= 4), 1);
  endtask

  task automatic run_move(input int f, input int t, input int p, input string tag);
    string e;
    e  = expect_reply(f, t, p);
    s1 = "";
    s2 = "";
    start_move(f, t, p);
    wait_idle(600, {tag, "_timeout"});
    chk_str({tag, "_dut1"}, s1, e);
    chk_str({tag, "_dut2"}, s2, e);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d1b, d2b, f, t, p;
    string ea, eb;

    rst_in         = 1'b1;
    move_from_in   = '0;
    move_to_in     = '0;
    move_promo_in  = '0;
    move_valid_in  = 1'b0;
    char_out_ready = 1'b0;
    repeat (3) step();
    chk("reset_dut1", {19'd0, c1, v1, busy1, drop1, se1}, 0);
    chk("reset_dut2", {19'd0, c2, v2, busy2, drop2, se2}, 0);
    rst_in = 1'b0;
    step();

    // e2e4 with ready high: latency, throughput and busy timing.
    char_out_ready = 1'b1;
    s1 = "";
    s2 = "";
    chk("e2e4_busy_before", 32'(busy1), 0);
    start_move(12, 28, 0);
    chk("e2e4_busy_rise", {30'd0, busy1, v1}, 32'b10);
    step();
    chk("e2e4_first_valid", {23'd0, v1, c1}, {23'd0, 1'b1, 8'h62});
    n = 0;
    while (busy1 && n < 40) begin
      step();
      n++;
    end
    chk("e2e4_busy_cycles", n, 13 + EOL_LEN);
    wait_idle(50, "e2e4_timeout");
    chk_str("e2e4_dut1", s1, expect_reply(12, 28, 0));
    chk_str("e2e4_dut2", s2, expect_reply(12, 28, 0));

    // Promotion and null-move rules.
    run_move(52, 60, 4, "e7e8q");
    run_move(52, 60, 6, "e7e8_promo6");
    run_move(0, 0, 0, "null");
    run_move(0, 0, 2, "null_promo2");

    // Randomised ready throttling.
    ready_rand = 1;
    run_move(0, 63, 0, "a1h8_rand");
    for (int i = 0; i < 8; i++) begin
      f = $urandom_range(0, 63);
      t = ($urandom_range(0, 3) == 0) ? f : $urandom_range(0, 63);
      p = $urandom_range(0, 7);
      run_move(f, t, p, $sformatf("rand%0d", i));
    end
    ready_rand     = 0;
    char_out_ready = 1'b1;

    // Moves A, B, C while A is in flight.
    s1  = "";
    s2  = "";
    d1b = nd1;
    d2b = nd2;
    start_move(12, 28, 0);
    repeat (3) step();
    start_move(11, 27, 0);
    repeat (2) step();
    start_move(6, 21, 1);
    wait_idle(200, "pend_timeout");
    chk_str("pend_dut1", s1, {expect_reply(12, 28, 0), expect_reply(6, 21, 1)});
    chk_str("pend_dut2", s2, expect_reply(12, 28, 0));
    chk("pend_drops_dut1", nd1 - d1b, 1);
    chk("pend_drops_dut2", nd2 - d2b, 2);

    // A move arriving in the cycle the final LF is transferred.
    s1  = "";
    s2  = "";
    d1b = nd1;
    d2b = nd2;
    ea  = expect_reply(12, 28, 0);
    eb  = expect_reply(6, 21, 0);
    start_move(12, 28, 0);
    n = 0;
    while (!(v1 && c1 == 8'h0A) && n < 60) begin
      @(negedge clk_in);
      n++;
    end
    chk("eol_seen", 32'(n < 60), 1);
    move_from_in  = 6'd6;
    move_to_in    = 6'd21;
    move_promo_in = 3'd0;
    move_valid_in = 1'b1;
    @(posedge clk_in);
    #1;
    move_valid_in = 1'b0;
    wait_idle(200, "eol_timeout");
    chk_str("eol_dut1", s1, {ea, eb});
    chk_str("eol_dut2", s2, ea);
    chk("eol_drops_dut1", nd1 - d1b, 0);
    chk("eol_drops_dut2", nd2 - d2b, 1);

    // Stall abort on dut1; dut2 has no limit and keeps waiting.
    s1 = "";
    s2 = "";
    char_out_ready = 1'b0;
    start_move(12, 28, 0);
    step();
    chk("stall_valid_up", 32'(v1), 1);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("stall_hold_valid", {30'd0, v1, se1}, 32'b10);
    end
    step();
    chk("stall_abort_dut1", {29'd0, v1, se1, busy1}, 32'b010);
    chk("stall_dut2_waiting", {30'd0, v2, busy2}, 32'b11);
    step();
    chk("stall_err_pulse_end", 32'(se1), 0);
    char_out_ready = 1'b1;
    wait_idle(100, "stall_timeout");
    chk_str("stall_dut1", s1, "");
    chk_str("stall_dut2", s2, expect_reply(12, 28, 0));

    // Reset in the middle of a reply, then a fresh reply.
    start_move(52, 60, 4);
    repeat (4) step();
    rst_in = 1'b1;
    step();
    chk("rst_mid_dut1", {19'd0, c1, v1, busy1, drop1, se1}, 0);
    chk("rst_mid_dut2", {19'd0, c2, v2, busy2, drop2, se2}, 0);
    rst_in = 1'b0;
    step();
    run_move(1, 18, 3, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
